bus_sync_tx_ctrl: RTL and testbench

BUS_SYNC_TX_CTRL -- requirements
Module: bus_sync_tx_ctrl

---
 rtl/bus_sync_pkg.sv | 15 +
 rtl/bit_sync.sv | 27 ++
 rtl/bus_sync_tx_ctrl.sv | 106 ++++++++++
 tb/tb_bus_sync_tx_ctrl.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_sync_pkg.sv
// rtl/bus_sync_pkg.sv - shared state encoding and helpers for the bus sync sender
package bus_sync_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_REL  = 2'd2
    } state_t;

    // Counter width able to hold timeout-1; never narrower than one bit.
    function automatic int cnt_width(input int timeout);
        return (timeout > 1) ? $clog2(timeout) : 1;
    endfunction

endpackage

// File: rtl/bit_sync.sv
// rtl/bit_sync.sv - multi-flop single-bit level synchronizer
module bit_sync #(
    parameter int NUM_STAGES = 2
) (
    input  logic CLK,
    input  logic Reset,
    input  logic in,
    output logic out
);

    logic [NUM_STAGES-1:0] stages;

    // Shift the asynchronous level through the flop chain; stage 0 takes the raw input.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            stages <= '0;
        end else begin
            stages[0] <= in;
            for (int i = 1; i < NUM_STAGES; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign out = stages[NUM_STAGES-1];

endmodule

// File: rtl/bus_sync_tx_ctrl.sv
// rtl/bus_sync_tx_ctrl.sv - four-phase req/ack sender for a held bus word
module bus_sync_tx_ctrl
    import bus_sync_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int NUM_STAGES = 2,
    parameter int TIMEOUT    = 255
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Async_bus,
    output logic             bus_EN,
    input  logic             ack_async,
    output logic             busy,
    output logic             done,
    output logic             err_timeout
);

    localparam int             CW       = cnt_width(TIMEOUT);
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT - 1);

    state_t          state;
    logic [CW-1:0]   wait_cnt;
    logic            acked;
    logic            ack_sync;

    bit_sync #(
        .NUM_STAGES(NUM_STAGES)
    ) u_ack_sync (
        .CLK  (CLK),
        .Reset(Reset),
        .in   (ack_async),
        .out  (ack_sync)
    );

    assign in_ready = (state == ST_IDLE);
    assign busy     = (state != ST_IDLE);

    // Handshake sequencer: capture in IDLE, request until ack or timeout, then wait for ack release.
    // acked remembers whether the transfer completed cleanly so done is only raised for real handshakes.
    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state       <= ST_IDLE;
            Async_bus   <= '0;
            bus_EN      <= 1'b0;
            done        <= 1'b0;
            err_timeout <= 1'b0;
            wait_cnt    <= '0;
            acked       <= 1'b0;
        end else begin
            done        <= 1'b0;
            err_timeout <= 1'b0;
            case (state)
                ST_IDLE: begin
                    wait_cnt <= '0;
                    if (in_valid) begin
                        Async_bus <= in_data;
                        bus_EN    <= 1'b1;
                        acked     <= 1'b0;
                        state     <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (ack_sync) begin
                        bus_EN   <= 1'b0;
                        acked    <= 1'b1;
                        wait_cnt <= '0;
                        state    <= ST_REL;
                    end else if (wait_cnt == CNT_LAST) begin
                        bus_EN      <= 1'b0;
                        acked       <= 1'b0;
                        err_timeout <= 1'b1;
                        wait_cnt    <= '0;
                        state       <= ST_REL;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                ST_REL: begin
                    if (!ack_sync) begin
                        done     <= acked;
                        acked    <= 1'b0;
                        wait_cnt <= '0;
                        state    <= ST_IDLE;
                    end else if (wait_cnt == CNT_LAST) begin
                        // A stuck acknowledge spoils the transfer; keep waiting but never report done.
                        err_timeout <= 1'b1;
                        acked       <= 1'b0;
                        wait_cnt    <= '0;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: begin
                    bus_EN   <= 1'b0;
                    wait_cnt <= '0;
                    state    <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_sync_tx_ctrl.sv
// tb/tb_bus_sync_tx_ctrl.sv - scoreboard bench for bus_sync_tx_ctrl
module tb_bus_sync_tx_ctrl;

    localparam int WIDTH      = 8;
    localparam int NUM_STAGES = 2;
    localparam int TIMEOUT    = 16;

    logic             clk = 1'b0;
    logic             reset;
    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] Async_bus;
    logic             bus_EN;
    logic             ack_async;
    logic             busy;
    logic             done;
    logic             err_timeout;

    int checks = 0;
    int fails  = 0;
    int done_cnt = 0;
    int err_cnt  = 0;

    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_word = '0;
    logic [WIDTH-1:0] exp_word;
    logic prev_en = 1'b0, prev_done = 1'b0, prev_err = 1'b0;

    bus_sync_tx_ctrl #(
        .WIDTH(WIDTH), .NUM_STAGES(NUM_STAGES), .TIMEOUT(TIMEOUT)
    ) dut (
        .CLK(clk), .Reset(reset), .in_data(in_data), .in_valid(in_valid),
        .in_ready(in_ready), .Async_bus(Async_bus), .bus_EN(bus_EN),
        .ack_async(ack_async), .busy(busy), .done(done), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor: push on handshake, pop on request rise, track held word and pulses.
    always @(negedge clk) begin
        if (reset) begin
            last_word = '0;
            prev_en = 1'b0; prev_done = 1'b0; prev_err = 1'b0;
            exp_q.delete();
        end else begin
            checks++;
            if (Async_bus !== last_word) begin
                fails++;
                $display("FAIL bus_hold: Async_bus=%h expected %h at %0t", Async_bus, last_word, $time);
            end
            if (bus_EN && !prev_en) begin
                checks++;
                if (exp_q.size() == 0) begin
                    fails++;
                    $display("FAIL sb_empty: bus_EN rose with no queued word, Async_bus=%h", Async_bus);
                end else begin
                    exp_word = exp_q.pop_front();
                    if (Async_bus !== exp_word) begin
                        fails++;
                        $display("FAIL sb_word: Async_bus=%h expected %h", Async_bus, exp_word);
                    end
                end
            end
            if (done) done_cnt++;
            if (err_timeout) err_cnt++;
            checks++;
            if ((done && prev_done) || (err_timeout && prev_err)) begin
                fails++;
                $display("FAIL pulse_width: done=%b/%b err=%b/%b expected single-cycle pulses", prev_done, done, prev_err, err_timeout);
            end
            if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
                last_word = in_data;
            end
            prev_en = bus_EN; prev_done = done; prev_err = err_timeout;
        end
    end

    task automatic step();
        @(posedge clk); #1;
    endtask

    function automatic logic pick(input int sel);
        case (sel)
            0:       return bus_EN;
            1:       return in_ready;
            default: return err_timeout;
        endcase
    endfunction

    // Returns number of steps until the selected signal equals val, or max+1 if it never does.
    task automatic wait_for(input int sel, input logic val, input int max, output int n);
        n = max + 1;
        for (int i = 1; i <= max; i++) begin
            step();
            if (pick(sel) === val) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; in_valid = 1'b0; in_data = '0; ack_async = 1'b0;
        #1;
        checks++;
        if ({in_ready, busy, bus_EN, done, err_timeout} !== 5'b10000 || Async_bus !== 8'h00) begin
            fails++;
            $display("FAIL reset_state: rdy/busy/en/done/err=%b bus=%h expected 10000 00",
                     {in_ready, busy, bus_EN, done, err_timeout}, Async_bus);
        end
        repeat (3) step();
        reset = 1'b0;
        step();
        checks++;
        if (in_ready !== 1'b1 || busy !== 1'b0 || bus_EN !== 1'b0) begin
            fails++;
            $display("FAIL post_reset: in_ready=%b busy=%b bus_EN=%b expected 1 0 0", in_ready, busy, bus_EN);
        end
    endtask

    task automatic test_single();
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        in_data = 8'hA5; in_valid = 1'b1;
        step();
        in_valid = 1'b0; in_data = 8'h00;
        checks++;
        if (bus_EN !== 1'b1 || Async_bus !== 8'hA5 || in_ready !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL single_capture: en=%b bus=%h rdy=%b busy=%b expected 1 a5 0 1", bus_EN, Async_bus, in_ready, busy);
        end
        repeat (3) step();
        ack_async = 1'b1;
        wait_for(0, 1'b0, 10, n);
        checks++;
        if (n !== 3) begin
            fails++;
            $display("FAIL single_rel_latency: %0d cycles expected 3", n);
        end
        repeat (3) step();
        ack_async = 1'b0;
        wait_for(1, 1'b1, 10, n);
        checks++;
        if (n !== 3 || done !== 1'b1) begin
            fails++;
            $display("FAIL single_idle: %0d cycles done=%b expected 3 1", n, done);
        end
        step();
        checks++;
        if (done !== 1'b0 || done_cnt - d0 !== 1 || err_cnt - e0 !== 0) begin
            fails++;
            $display("FAIL single_pulses: done=%b dones=%0d errs=%0d expected 0 1 0", done, done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_back_to_back();
        int n, d0;
        d0 = done_cnt;
        in_data = 8'h11; in_valid = 1'b1;
        for (int t = 0; t < 2; t++) begin
            wait_for(0, 1'b1, 5, n);
            checks++;
            if (n !== 1) begin
                fails++;
                $display("FAIL b2b_capture%0d: %0d cycles expected 1", t, n);
            end
            if (t == 0) in_data = 8'h22;
            else        in_valid = 1'b0;
            repeat (2) step();
            ack_async = 1'b1;
            wait_for(0, 1'b0, 10, n);
            checks++;
            if (n !== 3 || in_ready !== 1'b0) begin
                fails++;
                $display("FAIL b2b_rel%0d: %0d cycles in_ready=%b expected 3 0", t, n, in_ready);
            end
            ack_async = 1'b0;
            wait_for(1, 1'b1, 10, n);
            checks++;
            if (n !== 3 || done !== 1'b1) begin
                fails++;
                $display("FAIL b2b_done%0d: %0d cycles done=%b expected 3 1", t, n, done);
            end
        end
        step();
        checks++;
        if (done_cnt - d0 !== 2 || exp_q.size() !== 0) begin
            fails++;
            $display("FAIL b2b_count: dones=%0d queue=%0d expected 2 0", done_cnt - d0, exp_q.size());
        end
    endtask

    task automatic test_req_timeout();
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        in_data = 8'h3C; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        wait_for(0, 1'b0, 20, n);
        checks++;
        if (n !== TIMEOUT || err_timeout !== 1'b1) begin
            fails++;
            $display("FAIL req_timeout: en held %0d cycles err=%b expected %0d 1", n, err_timeout, TIMEOUT);
        end
        step();
        checks++;
        if (err_timeout !== 1'b0 || in_ready !== 1'b1 || done !== 1'b0) begin
            fails++;
            $display("FAIL req_timeout_idle: err=%b rdy=%b done=%b expected 0 1 0", err_timeout, in_ready, done);
        end
        step();
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 1) begin
            fails++;
            $display("FAIL req_timeout_count: dones=%0d errs=%0d expected 0 1", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_rel_timeout();
        int n, d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        in_data = 8'h5A; in_valid = 1'b1;
        step();
        in_valid = 1'b0; ack_async = 1'b1;
        wait_for(0, 1'b0, 10, n);
        checks++;
        if (n !== 3) begin
            fails++;
            $display("FAIL rel_enter: %0d cycles expected 3", n);
        end
        for (int k = 0; k < 3; k++) begin
            wait_for(2, 1'b1, 20, n);
            checks++;
            if (n !== TIMEOUT || bus_EN !== 1'b0 || busy !== 1'b1) begin
                fails++;
                $display("FAIL rel_timeout%0d: %0d cycles en=%b busy=%b expected %0d 0 1", k, n, bus_EN, busy, TIMEOUT);
            end
        end
        ack_async = 1'b0;
        wait_for(1, 1'b1, 10, n);
        checks++;
        if (n !== 3 || done !== 1'b0) begin
            fails++;
            $display("FAIL rel_release: %0d cycles done=%b expected 3 0", n, done);
        end
        step();
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 3) begin
            fails++;
            $display("FAIL rel_count: dones=%0d errs=%0d expected 0 3", done_cnt - d0, err_cnt - e0);
        end
    endtask

    task automatic test_spurious_ack();
        int d0, e0;
        d0 = done_cnt; e0 = err_cnt;
        for (int i = 0; i < 20; i++) begin
            if (i % 3 == 0) ack_async = ~ack_async;
            step();
            checks++;
            if (in_ready !== 1'b1 || bus_EN !== 1'b0 || done !== 1'b0 || err_timeout !== 1'b0) begin
                fails++;
                $display("FAIL spurious%0d: rdy=%b en=%b done=%b err=%b expected 1 0 0 0", i, in_ready, bus_EN, done, err_timeout);
            end
        end
        ack_async = 1'b0;
        repeat (4) step();
        checks++;
        if (done_cnt - d0 !== 0 || err_cnt - e0 !== 0 || in_ready !== 1'b1) begin
            fails++;
            $display("FAIL spurious_count: dones=%0d errs=%0d rdy=%b expected 0 0 1", done_cnt - d0, err_cnt - e0, in_ready);
        end
    endtask

    task automatic test_reset_mid();
        int d0;
        d0 = done_cnt;
        in_data = 8'h77; in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step();
        checks++;
        if (bus_EN !== 1'b1 || Async_bus !== 8'h77) begin
            fails++;
            $display("FAIL mid_setup: en=%b bus=%h expected 1 77", bus_EN, Async_bus);
        end
        #2 reset = 1'b1;
        #1;
        checks++;
        if (bus_EN !== 1'b0 || Async_bus !== 8'h00 || in_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
            fails++;
            $display("FAIL mid_reset: en=%b bus=%h rdy=%b done=%b busy=%b expected 0 00 1 0 0",
                     bus_EN, Async_bus, in_ready, done, busy);
        end
        repeat (2) step();
        reset = 1'b0;
        repeat (4) step();
        checks++;
        if (done_cnt - d0 !== 0 || in_ready !== 1'b1 || Async_bus !== 8'h00) begin
            fails++;
            $display("FAIL mid_after: dones=%0d rdy=%b bus=%h expected 0 1 00", done_cnt - d0, in_ready, Async_bus);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_req_timeout();
        test_rel_timeout();
        test_spurious_ack();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

endmodule
